// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared LSU types, memory size codes and the byte-enable helper.
package riscv_lsu_pkg;
  localparam int MSIZE_WIDTH = 3;

  typedef enum logic [1:0] {ADP_IDLE, ADP_REQ, ADP_WAIT} dmem_adp_state_t;

  localparam logic [MSIZE_WIDTH-1:0] MSIZE_B  = 3'b000;
  localparam logic [MSIZE_WIDTH-1:0] MSIZE_H  = 3'b001;
  localparam logic [MSIZE_WIDTH-1:0] MSIZE_W  = 3'b010;
  localparam logic [MSIZE_WIDTH-1:0] MSIZE_BU = 3'b100;
  localparam logic [MSIZE_WIDTH-1:0] MSIZE_HU = 3'b101;

  function automatic logic [3:0] be_gen(input logic [MSIZE_WIDTH-1:0] size, input logic [1:0] addr);
    return size == MSIZE_W ? 4'b1111 : (size[0] ? 4'b0011 : 4'b0001) << addr;
  endfunction
endpackage

// File: rtl/riscv_load_align.sv
// riscv_load_align: extracts the addressed byte/half from a raw word and sign/zero-extends it.
module riscv_load_align
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]        word_i,
  input  logic [1:0]             off_i,
  input  logic [MSIZE_WIDTH-1:0] size_i,
  output logic [XLEN-1:0]        data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word_i[{off_i, 3'b000} +: 8];
    h = word_i[{off_i[1], 4'b0000} +: 16];
    data_o = size_i[1:0] == 2'b00 ? {{(XLEN-8){b[7] & ~size_i[2]}}, b} :
             size_i[1:0] == 2'b01 ? {{(XLEN-16){h[15] & ~size_i[2]}}, h} : word_i;
  end
endmodule

// File: rtl/riscv_dmem_adapter.sv
// riscv_dmem_adapter: LSU to data-memory bus bridge with alignment checks and load extension.
// Define RISCV_DMEM_RESP_REG_EN to register the bus response before extension (one extra cycle).
module riscv_dmem_adapter
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BE_WIDTH = XLEN / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   lsu_req_i,
  input  logic                   lsu_we_i,
  input  logic [MSIZE_WIDTH-1:0] lsu_size_i,
  input  logic [XLEN-1:0]        lsu_addr_i,
  input  logic [XLEN-1:0]        lsu_wdata_i,
  output logic                   lsu_busy_o,
  output logic                   lsu_done_o,
  output logic [XLEN-1:0]        lsu_rdata_o,
  output logic                   lsu_misalign_o,
  output logic                   lsu_fault_o,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [BE_WIDTH-1:0]    dmem_be_o,
  output logic [XLEN-1:0]        dmem_addr_o,
  output logic [XLEN-1:0]        dmem_wdata_o,
  input  logic                   dmem_gnt_i,
  input  logic                   dmem_rvalid_i,
  input  logic [XLEN-1:0]        dmem_rdata_i,
  input  logic                   dmem_err_i
);
  dmem_adp_state_t state_q, state_d;
  logic req_q, we_q, done_q, misalign_q, fault_q;
  logic [BE_WIDTH-1:0] be_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, rsp_word, ext;
  logic [MSIZE_WIDTH-1:0] size_q;
  logic [1:0] off_q;
  logic idle, legal, misal, accept, reject, rsp_fire, rsp_err;

  assign idle   = state_q == ADP_IDLE;
  assign legal  = lsu_size_i inside {MSIZE_B, MSIZE_H, MSIZE_W, MSIZE_BU, MSIZE_HU};
  assign misal  = (lsu_size_i[1:0] == 2'b01 && lsu_addr_i[0]) ||
                  (lsu_size_i == MSIZE_W && lsu_addr_i[1:0] != 2'b00);
  assign accept = idle && lsu_req_i && legal && !misal;
  assign reject = idle && lsu_req_i && !accept;

`ifdef RISCV_DMEM_RESP_REG_EN
  // FSM stays in ADP_WAIT while the captured response is being extended.
  logic resp_q, err_q;
  logic [XLEN-1:0] word_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;
      word_q <= '0;
    end else begin
      resp_q <= state_q == ADP_WAIT && dmem_rvalid_i && !resp_q;
      if (state_q == ADP_WAIT && dmem_rvalid_i && !resp_q) begin
        word_q <= dmem_rdata_i;
        err_q  <= dmem_err_i;
      end
    end
  end
  assign rsp_fire = resp_q;
  assign rsp_word = word_q;
  assign rsp_err  = err_q;
`else
  assign rsp_fire = state_q == ADP_WAIT && dmem_rvalid_i;
  assign rsp_word = dmem_rdata_i;
  assign rsp_err  = dmem_err_i;
`endif

  riscv_load_align #(.XLEN(XLEN)) u_align (
    .word_i (rsp_word),
    .off_i  (off_q),
    .size_i (size_q),
    .data_o (ext)
  );

  always_comb begin
    state_d = state_q;
    state_d = idle ? (accept ? ADP_REQ : ADP_IDLE) :
              state_q == ADP_REQ ? (dmem_gnt_i ? ADP_WAIT : ADP_REQ) :
              (rsp_fire ? ADP_IDLE : ADP_WAIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ADP_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      off_q      <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= rsp_fire || reject;
      misalign_q <= reject && legal;
      fault_q    <= rsp_fire ? rsp_err : reject && !legal;
      if (rsp_fire) rdata_q <= we_q ? '0 : ext;
      if (accept) begin
        req_q   <= 1'b1;
        we_q    <= lsu_we_i;
        be_q    <= be_gen(lsu_size_i, lsu_addr_i[1:0]);
        addr_q  <= {lsu_addr_i[XLEN-1:2], 2'b00};
        wdata_q <= lsu_size_i[1:0] == 2'b00 ? {BE_WIDTH{lsu_wdata_i[7:0]}} :
                   lsu_size_i[1:0] == 2'b01 ? {(BE_WIDTH/2){lsu_wdata_i[15:0]}} : lsu_wdata_i;
        size_q  <= lsu_size_i;
        off_q   <= lsu_addr_i[1:0];
      end else if (state_q == ADP_REQ && dmem_gnt_i) begin
        req_q <= 1'b0;
      end
    end
  end

  assign lsu_busy_o     = !idle;
  assign lsu_done_o     = done_q;
  assign lsu_rdata_o    = rdata_q;
  assign lsu_misalign_o = misalign_q;
  assign lsu_fault_o    = fault_q;
  assign dmem_req_o     = req_q;
  assign dmem_we_o      = we_q;
  assign dmem_be_o      = be_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_wdata_o   = wdata_q;
endmodule

// File: tb/tb_riscv_dmem_adapter.sv
// tb_riscv_dmem_adapter: scenario tasks with a completion scoreboard for riscv_dmem_adapter.
module tb_riscv_dmem_adapter;
  import riscv_lsu_pkg::*;

`ifdef RISCV_DMEM_RESP_REG_EN
  localparam int BASE_LAT = 4;
`else
  localparam int BASE_LAT = 3;
`endif

  typedef struct packed {logic [31:0] rdata; logic mis; logic flt;} exp_t;
  typedef struct packed {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} bus_t;

  logic clk = 0, rst = 1;
  logic lsu_req = 0, lsu_we = 0;
  logic [2:0] lsu_size = 0;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0;
  logic lsu_busy, lsu_done, lsu_misalign, lsu_fault;
  logic [31:0] lsu_rdata;
  logic dmem_req, dmem_we;
  logic [3:0] dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic dmem_gnt = 0, dmem_rvalid = 0, dmem_err = 0;
  logic [31:0] dmem_rdata = 0;

  int n_checks = 0, n_fail = 0;
  exp_t sbq[$];
  exp_t e;
  logic prev_done = 0;
  logic [31:0] last = 0;

  always #5 clk = ~clk;

  riscv_dmem_adapter dut (
    .clk_i(clk), .rst_i(rst),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_busy_o(lsu_busy), .lsu_done_o(lsu_done), .lsu_rdata_o(lsu_rdata),
    .lsu_misalign_o(lsu_misalign), .lsu_fault_o(lsu_fault),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_be_o(dmem_be),
    .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i(dmem_rdata), .dmem_err_i(dmem_err)
  );

  always @(negedge clk) begin
    if (lsu_done) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done with rdata=%h mis=%b flt=%b, required no completion", lsu_rdata, lsu_misalign, lsu_fault);
      end else begin
        e = sbq.pop_front();
        if ({lsu_rdata, lsu_misalign, lsu_fault} !== e) begin
          n_fail++;
          $display("FAIL completion: got rdata=%h mis=%b flt=%b, required rdata=%h mis=%b flt=%b",
                   lsu_rdata, lsu_misalign, lsu_fault, e.rdata, e.mis, e.flt);
        end
      end
    end
    if ((lsu_misalign || lsu_fault) && !lsu_done) begin
      n_checks++; n_fail++;
      $display("FAIL status_without_done: got mis=%b flt=%b with done=0, required 0", lsu_misalign, lsu_fault);
    end
    if (prev_done && lsu_done) begin
      n_checks++; n_fail++;
      $display("FAIL double_done: got done in consecutive cycles, required single pulse");
    end
    prev_done = lsu_done;
  end

  function automatic logic [31:0] model_load(logic [31:0] w, logic [1:0] off, logic [2:0] sz);
    logic [31:0] s = w >> (8 * off);
    case (sz)
      3'b000: return 32'($signed(s[7:0]));
      3'b001: return 32'($signed(s[15:0]));
      3'b100: return {24'h0, s[7:0]};
      3'b101: return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input int gd, input logic [31:0] rd, input logic er,
                        output int lat, output bus_t snap, output logic stable, output logic drop_ok, output int req_cyc);
    int wc = 0;
    int ph = 0;
    lat = -1; stable = 1; drop_ok = 1; req_cyc = 0; snap = '0;
    @(negedge clk);
    lsu_req = 1; lsu_we = we; lsu_size = sz; lsu_addr = a; lsu_wdata = wd;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (lsu_done) begin lat = c; lsu_req = 0; end
      dmem_gnt = 0; dmem_rvalid = 0;
      if (dmem_req) begin
        if (req_cyc == 0) snap = {dmem_we, dmem_be, dmem_addr, dmem_wdata};
        else if (snap !== {dmem_we, dmem_be, dmem_addr, dmem_wdata}) stable = 0;
        req_cyc++;
      end
      if (ph == 1) begin
        drop_ok = !dmem_req;
        dmem_rvalid = 1; dmem_rdata = rd; dmem_err = er; ph = 2;
      end else if (ph == 0 && dmem_req) begin
        if (wc == gd) begin dmem_gnt = 1; ph = 1; end
        wc++;
      end
    end
    lsu_req = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_err = 0;
  endtask

  task automatic test_reset();
    lsu_req = 1; lsu_size = MSIZE_W; lsu_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({lsu_busy, lsu_done, lsu_rdata, lsu_misalign, lsu_fault, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got busy=%b done=%b rdata=%h req=%b be=%h addr=%h wdata=%h, required all 0",
                 lsu_busy, lsu_done, lsu_rdata, dmem_req, dmem_be, dmem_addr, dmem_wdata);
      end
    end
    lsu_req = 0;
    rst = 0;
  endtask

  task automatic test_load_byte();
    int lat, rc; bus_t s; logic st, dr;
    sbq.push_back({32'hFFFF_FF80, 1'b0, 1'b0});
    access(0, MSIZE_B, 32'h1003, 32'h0, 0, 32'h80FF_1234, 0, lat, s, st, dr, rc);
    last = 32'hFFFF_FF80;
    n_checks++; if (lat !== BASE_LAT) begin n_fail++; $display("FAIL lb_latency: got %0d required %0d", lat, BASE_LAT); end
    n_checks++; if (s.be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b required 1000", s.be); end
    n_checks++; if (s.addr !== 32'h1000) begin n_fail++; $display("FAIL lb_addr: got %h required 00001000", s.addr); end
    n_checks++; if ({s.we, rc, dr} !== {1'b0, 32'd1, 1'b1}) begin n_fail++; $display("FAIL lb_handshake: got we=%b req_cycles=%0d drop=%b required 0 1 1", s.we, rc, dr); end
  endtask

  task automatic test_reject();
    int lat, rc; bus_t s; logic st, dr;
    sbq.push_back({last, 1'b1, 1'b0});
    access(0, MSIZE_W, 32'h3001, 32'h0, 0, 32'h0, 0, lat, s, st, dr, rc);
    n_checks++; if ({lat, rc} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL lw_misalign: got lat=%0d req_cycles=%0d required 1 0", lat, rc); end
    sbq.push_back({last, 1'b0, 1'b1});
    access(0, 3'b011, 32'h3000, 32'h0, 0, 32'h0, 0, lat, s, st, dr, rc);
    n_checks++; if ({lat, rc} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL illegal_size: got lat=%0d req_cycles=%0d required 1 0", lat, rc); end
    sbq.push_back({last, 1'b1, 1'b0});
    access(0, MSIZE_HU, 32'h3003, 32'h0, 0, 32'h0, 0, lat, s, st, dr, rc);
    n_checks++; if ({lat, rc} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL lhu_misalign: got lat=%0d req_cycles=%0d required 1 0", lat, rc); end
  endtask

  task automatic test_store_half();
    int lat, rc; bus_t s; logic st, dr;
    sbq.push_back({32'h0, 1'b0, 1'b0});
    access(1, MSIZE_H, 32'h2002, 32'h0000_ABCD, 0, 32'hDEAD_BEEF, 0, lat, s, st, dr, rc);
    last = 32'h0;
    n_checks++; if (s.wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h required abcdabcd", s.wdata); end
    n_checks++; if ({s.we, s.be, s.addr} !== {1'b1, 4'b1100, 32'h2000}) begin n_fail++; $display("FAIL sh_bus: got we=%b be=%b addr=%h required 1 1100 00002000", s.we, s.be, s.addr); end
    n_checks++; if (lat !== BASE_LAT) begin n_fail++; $display("FAIL sh_latency: got %0d required %0d", lat, BASE_LAT); end
  endtask

  task automatic test_gnt_stall();
    int lat, rc; bus_t s; logic st, dr;
    sbq.push_back({32'h0, 1'b0, 1'b0});
    access(1, MSIZE_W, 32'h6004, 32'h1234_5678, 5, 32'h0, 0, lat, s, st, dr, rc);
    n_checks++; if (rc !== 6) begin n_fail++; $display("FAIL stall_req_cycles: got %0d required 6", rc); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL stall_stable: got %b required 1", st); end
    n_checks++; if (dr !== 1'b1) begin n_fail++; $display("FAIL stall_req_drop: got %b required 1", dr); end
    n_checks++; if ({s.be, s.addr, s.wdata} !== {4'hF, 32'h6004, 32'h1234_5678}) begin n_fail++; $display("FAIL stall_bus: got be=%h addr=%h wdata=%h", s.be, s.addr, s.wdata); end
    n_checks++; if (lat !== BASE_LAT + 5) begin n_fail++; $display("FAIL stall_latency: got %0d required %0d", lat, BASE_LAT + 5); end
  endtask

  task automatic test_load_err();
    int lat, rc; bus_t s; logic st, dr;
    sbq.push_back({32'h0000_8001, 1'b0, 1'b1});
    access(0, MSIZE_HU, 32'h4002, 32'h0, 0, 32'h8001_0000, 1, lat, s, st, dr, rc);
    last = 32'h0000_8001;
    n_checks++; if ({lat, s.be} !== {BASE_LAT, 4'b1100}) begin n_fail++; $display("FAIL lhu_err: got lat=%0d be=%b required %0d 1100", lat, s.be, BASE_LAT); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] szs [5] = '{MSIZE_B, MSIZE_H, MSIZE_W, MSIZE_BU, MSIZE_HU};
    for (int i = 0; i < 8; i++) begin
      int lat, rc, gd; bus_t s; logic st, dr, we;
      logic [2:0] sz; logic [1:0] off; logic [31:0] w, wd, ex, ew; logic [3:0] eb;
      we = i[0];
      sz = szs[we ? $urandom_range(0, 2) : $urandom_range(0, 4)];
      off = 2'($urandom_range(0, 3));
      if (sz[1]) off = 0; else if (sz[0]) off[0] = 0;
      w = $urandom(); wd = $urandom(); gd = $urandom_range(0, 2);
      ex = we ? 32'h0 : model_load(w, off, sz);
      eb = sz[1] ? 4'hF : 4'((sz[0] ? 3 : 1) << off);
      ew = sz[1] ? wd : sz[0] ? {2{wd[15:0]}} : {4{wd[7:0]}};
      sbq.push_back({ex, 1'b0, 1'b0});
      access(we, sz, 32'h7000 + 32'(i * 16) + 32'(off), wd, gd, w, 0, lat, s, st, dr, rc);
      last = ex;
      n_checks++;
      if ({lat, s.we, s.be, s.addr, s.wdata} !== {BASE_LAT + gd, we, eb, 32'h7000 + 32'(i * 16), ew}) begin
        n_fail++;
        $display("FAIL b2b_%0d: got lat=%0d we=%b be=%b addr=%h wdata=%h required %0d %b %b %h %h",
                 i, lat, s.we, s.be, s.addr, s.wdata, BASE_LAT + gd, we, eb, 32'h7000 + 32'(i * 16), ew);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, rc; bus_t s; logic st, dr;
    sbq.push_back({32'hCAFE_F00D, 1'b0, 1'b0});
    access(0, MSIZE_W, 32'h5000, 32'h0, 0, 32'hCAFE_F00D, 0, lat, s, st, dr, rc);
    @(negedge clk);
    lsu_req = 1; lsu_we = 0; lsu_size = MSIZE_W; lsu_addr = 32'h5004;
    @(negedge clk);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    n_checks++; if ({lsu_busy, dmem_req} !== 2'b10) begin n_fail++; $display("FAIL mid_wait_state: got busy=%b req=%b required 1 0", lsu_busy, dmem_req); end
    rst = 1; lsu_req = 0;
    @(negedge clk);
    rst = 0;
    n_checks++;
    if ({lsu_busy, lsu_done, lsu_rdata, lsu_misalign, lsu_fault, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b rdata=%h req=%b be=%h addr=%h, required all 0",
               lsu_busy, lsu_done, lsu_rdata, dmem_req, dmem_be, dmem_addr);
    end
    dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_rvalid = 0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if ({lsu_done, lsu_busy} !== 2'b00) begin n_fail++; $display("FAIL stray_rvalid: got done=%b busy=%b required 0 0", lsu_done, lsu_busy); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_reject();
    test_store_half();
    test_gnt_stall();
    test_load_err();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sbq.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
